// File: rtl/btn_click_decoder.sv
// btn_click_decoder: groups debounced button presses into single, double and
// triple click gestures using a press-to-press grouping window, and emits a
// one-cycle strobe per gesture along with a wrapping gesture counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no gesture in progress, waiting for the first press
// WAIT1 | one press collected, waiting for a second press or timeout
// WAIT2 | two presses collected, waiting for a third press or timeout
module btn_click_decoder #(
  parameter int CLOCK_FREQ = 100,
  parameter int T_WINDOW   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pulse,
  output logic       click_single,
  output logic       click_double,
  output logic       click_triple,
  output logic [7:0] gesture_count,
  output logic       busy
);

  localparam int WINDOW_CYCLES = CLOCK_FREQ * 1000 * T_WINDOW;
  localparam int TW            = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } state_t;

  logic s1, s2, s3;
  logic [1:0] sync_vld;
  logic armed;
  logic press;

  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic emit_single, emit_double, emit_triple;

  // Synchronize the asynchronous press pulse and keep a delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn_pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Arm edge detection only after the synchronized input has been seen low,
  // so a pulse already high when reset releases is not taken as a press.
  // sync_vld marks when s2 holds a real post-reset sample rather than its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign press = s2 & ~s3 & armed;

  // State and window timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state, timer and gesture decode; a press always wins over a timeout.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    emit_single = 1'b0;
    emit_double = 1'b0;
    emit_triple = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = WAIT1;
          timer_d = '0;
        end
      end
      WAIT1: begin
        if (press) begin
          state_d = WAIT2;
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          state_d     = IDLE;
          emit_single = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT2: begin
        if (press) begin
          state_d     = IDLE;
          timer_d     = '0;
          emit_triple = 1'b1;
        end else if (timer_q == T_LAST) begin
          state_d     = IDLE;
          emit_double = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Registered strobes, gesture counter and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      click_single  <= 1'b0;
      click_double  <= 1'b0;
      click_triple  <= 1'b0;
      gesture_count <= 8'd0;
      busy          <= 1'b0;
    end else begin
      click_single <= emit_single;
      click_double <= emit_double;
      click_triple <= emit_triple;
      if (emit_single || emit_double || emit_triple) begin
        gesture_count <= gesture_count + 8'd1;
      end
      busy <= (state_d != IDLE);
    end
  end

endmodule
